inst_queue_n: RTL
=================

# inst_queue_n

Parametrised in-order instruction queue between fetch and decode. It generalises the fixed two-slot A/B instruction/PC pair to LANES slots per cycle, backed by a DEPTH-entry circular buffer. Fetch pushes up to LANES {pc, instr} pairs per cycle and decode consumes up to LANES per cycle. Flush support covers branch redirect, and a sticky overflow flag supports debug.

## Interface
- LANES, 2, instructions pushed/presented per cycle (>=1)
- DEPTH, 8, queue entries; power of two, >= 2*LANES
- XLEN, 32, width of pc and instr
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  LANES  per-lane push request; lane 0 is oldest
- in_pc  in  LANES*XLEN  lane i at bits [i*XLEN +: XLEN]
- in_instr  in  LANES*XLEN  same packing as in_pc
- in_ready  out  1  free entries >= LANES
- out_valid  out  LANES  lane i holds the (i+1)-th oldest entry
- out_pc  out  LANES*XLEN  head-relative entries, same packing
- out_instr  out  LANES*XLEN  same packing
- out_take  in  $clog2(LANES+1)  entries consumed this cycle
- flush  in  1  synchronous discard of all contents
- count  out  $clog2(DEPTH+1)  occupied entries
- ovf  out  1  sticky: a push was dropped

## Operation
- Storage: DEPTH x {pc, instr}, with rd_ptr and wr_ptr modulo DEPTH and a count register.
- Push accepted only when in_ready=1. The accepted count n_push is the number of contiguous asserted in_valid bits starting at lane 0. Lanes after the first deasserted bit are ignored.
- Lane i (i < n_push) writes slot (wr_ptr+i) mod DEPTH, then wr_ptr advances by n_push.
- Show-ahead output: out_valid[i] = (count > i). out_pc[i] and out_instr[i] come from slot (rd_ptr+i) mod DEPTH. Data on lanes with out_valid=0 is don't-care.
- Pop: n_take = min(out_take, number of valid output lanes). rd_ptr advances by n_take.
- Next count = count + n_push - n_take. Push and pop in the same cycle are legal.
- in_ready = (DEPTH - count) >= LANES. It is computed from the current count and does not anticipate a same-cycle pop.
- Overflow: if in_valid[0]=1 while in_ready=0, nothing is written and ovf is set. ovf clears only on reset or flush.
- Flush: rd_ptr, wr_ptr and count go to 0 and ovf goes to 0. Flush overrides a same-cycle push and pop; the pushed data is discarded.
- Priority: reset > flush > push/pop.

## Timing
- Reset (async assert, any time, including mid-operation): pointers 0, count 0, ovf 0, out_valid all 0, in_ready 1.
- Outputs out_valid, out_pc, out_instr, in_ready and count are combinational from registers only; there is no combinational in->out path.
- Latency: an entry pushed at edge k appears on out_* after edge k, i.e. in the next cycle.
- Pop: entries taken at edge k are replaced by the next-oldest entries after edge k.
- Full: count=DEPTH gives in_ready=0 and out_valid all 1.
- Empty: count=0 gives out_valid all 0, and out_take is ignored.
- Wrap-around: pointer arithmetic wraps modulo DEPTH with no gap. FIFO order is preserved across the wrap.
- Flush at edge k: out_valid is all 0 after edge k. A push in cycle k+1 is accepted normally.

## Test plan
LANES=2, DEPTH=8 unless stated otherwise.
- Reset then push: after reset, count=0 and in_ready=1. Push {0x00,0x04} with in_valid=11 → next cycle count=2, out_valid=11, out_pc={0x00,0x04}. out_take=1 → next cycle count=1, out_valid=01, out_pc[0]=0x04.
- Fill and overflow: four pushes of 2 (pc 0x00..0x1C) → count=8, in_ready=0. Push in_valid=11 → count stays 8, ovf=1, out_pc[0] stays 0x00.
- Simultaneous push and pop: at count=4, push 2 with out_take=1 → count=5. out_pc[0] is the second-oldest entry.
- Wrap ordering: stream pc 0x00..0x7C (32 instrs), pushing 2 and taking 2 per cycle after a 3-cycle head start. Popped pc sequence must be strictly +4 with no loss across multiple pointer wraps.
- Partial valid: in_valid=10 → nothing pushed, count unchanged. in_valid=01 → one entry pushed, count+1.
- Flush/reset mid-op: at count=6 with ovf=1, assert flush with a push of 2 → next cycle count=0, ovf=0, out_valid=00. Reset asserted mid-stream → outputs immediately return to reset values.

Source files
------------

// File: rtl/inst_queue_n.sv
// In-order fetch-to-decode instruction queue: LANES {pc, instr} pairs pushed and
// presented per cycle over a DEPTH-entry circular buffer, with flush and sticky overflow.
module inst_queue_n #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*XLEN-1:0]        in_pc,
  input  logic [LANES*XLEN-1:0]        in_instr,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*XLEN-1:0]        out_pc,
  output logic [LANES*XLEN-1:0]        out_instr,
  input  logic [$clog2(LANES+1)-1:0]   out_take,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(LANES+1);

  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            ovf_r;
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [XLEN-1:0] instr_mem_r [DEPTH];

  logic            in_ready_s;
  logic            run_s;
  logic [TW-1:0]   run_cnt_s;
  logic [TW-1:0]   n_push_s;
  logic [CW-1:0]   avail_s;
  logic [TW-1:0]   n_take_s;

  // Room for a full group of LANES, judged on the current occupancy only
  always_comb begin
    in_ready_s = (CW'(DEPTH) - count_r) >= CW'(LANES);
  end

  // Accepted pushes: contiguous valid lanes from lane 0, none when not ready
  always_comb begin
    run_s     = 1'b1;
    run_cnt_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (run_s && in_valid[i]) begin
        run_cnt_s = run_cnt_s + TW'(1);
      end else begin
        run_s = 1'b0;
      end
    end
    if (in_ready_s) begin
      n_push_s = run_cnt_s;
    end else begin
      n_push_s = '0;
    end
  end

  // Pops are clamped to the number of lanes currently presenting data
  always_comb begin
    if (count_r > CW'(LANES)) begin
      avail_s = CW'(LANES);
    end else begin
      avail_s = count_r;
    end
    if (CW'(out_take) < avail_s) begin
      n_take_s = out_take;
    end else begin
      n_take_s = TW'(avail_s);
    end
  end

  // Show-ahead view of the LANES oldest entries
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i]               = count_r > CW'(i);
      out_pc[i*XLEN +: XLEN]     = pc_mem_r[rd_ptr_r + PW'(i)];
      out_instr[i*XLEN +: XLEN]  = instr_mem_r[rd_ptr_r + PW'(i)];
    end
  end

  // Pointer, occupancy and sticky overflow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_r + PW'(n_take_s);
      wr_ptr_r <= wr_ptr_r + PW'(n_push_s);
      count_r  <= count_r + CW'(n_push_s) - CW'(n_take_s);
      if (in_valid[0] && !in_ready_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!flush && (TW'(i) < n_push_s)) begin
        pc_mem_r[wr_ptr_r + PW'(i)]    <= in_pc[i*XLEN +: XLEN];
        instr_mem_r[wr_ptr_r + PW'(i)] <= in_instr[i*XLEN +: XLEN];
      end
    end
  end

  assign in_ready = in_ready_s;
  assign count    = count_r;
  assign ovf      = ovf_r;

endmodule
